// File: rtl/acc_datapath_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_datapath_mc_if
//  Purpose  : Control/memory-side bus of the multi-accumulator datapath.
//             The master modport is the control unit / memory side, the slave
//             modport is the datapath itself.
//  Revision : 1.0  initial release
// ============================================================================
interface acc_datapath_mc_if #(
    parameter int DATA_WIDTH    = 11,
    parameter int OPERAND_WIDTH = 8,
    parameter int NUM_ACC       = 4,
    parameter int ACC_SEL_WIDTH = $clog2(NUM_ACC)
);
    // Control unit / memory driven
    logic [OPERAND_WIDTH-1:0] operand_in;
    logic [DATA_WIDTH-1:0]    data_memory_in;
    logic [ACC_SEL_WIDTH-1:0] acc_sel_in;
    logic [2:0]               op_alu_in;
    logic [1:0]               sel_A_in;
    logic                     sel_B_in;
    logic                     acc_wr_in;
    logic                     status_wr_in;
    logic                     mul_start_in;

    // Datapath driven
    logic [DATA_WIDTH-1:0]    data_out;
    logic [DATA_WIDTH-1:0]    ext_out;
    logic [OPERAND_WIDTH-1:0] data_memory_address_out;
    logic                     flag_Z_out;
    logic                     flag_N_out;
    logic                     flag_C_out;
    logic                     flag_V_out;
    logic                     busy_out;
    logic                     done_out;

    modport master (
        output operand_in, data_memory_in, acc_sel_in, op_alu_in, sel_A_in,
               sel_B_in, acc_wr_in, status_wr_in, mul_start_in,
        input  data_out, ext_out, data_memory_address_out, flag_Z_out,
               flag_N_out, flag_C_out, flag_V_out, busy_out, done_out
    );

    modport slave (
        input  operand_in, data_memory_in, acc_sel_in, op_alu_in, sel_A_in,
               sel_B_in, acc_wr_in, status_wr_in, mul_start_in,
        output data_out, ext_out, data_memory_address_out, flag_Z_out,
               flag_N_out, flag_C_out, flag_V_out, busy_out, done_out
    );
endinterface
`default_nettype wire

// File: rtl/acc_datapath_mc.sv
`default_nettype none
// ============================================================================
//  Module   : acc_datapath_mc
//  Purpose  : Bank of NUM_ACC accumulators, 8-op ALU with Z/N/C/V flags,
//             operand sign extension and a DATA_WIDTH-cycle shift-add
//             multiplier with start/busy/done handshake.
//  Options  : DATAPATH_SAT_EN - when defined, ADD/SUB results saturate on
//             signed overflow instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module acc_datapath_mc #(
    parameter int DATA_WIDTH    = 11,
    parameter int OPERAND_WIDTH = 8,
    parameter int NUM_ACC       = 4,
    parameter int ACC_SEL_WIDTH = $clog2(NUM_ACC)
) (
    input  wire logic        clock_in,
    input  wire logic        reset_in,
    acc_datapath_mc_if.slave bus_if
);

    localparam int MSB   = DATA_WIDTH - 1;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PRD_W = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_EXT  = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    // Elaboration-time sanity of the parameter set
    generate
        if (OPERAND_WIDTH > DATA_WIDTH) begin : g_bad_operand_width
            $error("OPERAND_WIDTH must not exceed DATA_WIDTH");
        end
        if ((NUM_ACC < 2) || ((NUM_ACC & (NUM_ACC - 1)) != 0)) begin : g_bad_num_acc
            $error("NUM_ACC must be a power of two and at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    acc_q [NUM_ACC];
    logic [1:0]               state_q;
    logic [PRD_W-1:0]         mcand_q;
    logic [DATA_WIDTH-1:0]    mplier_q;
    logic [PRD_W-1:0]         product_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [ACC_SEL_WIDTH-1:0] dest_q;
    logic                     flag_z_q;
    logic                     flag_n_q;
    logic                     flag_c_q;
    logic                     flag_v_q;

    // ------------------------------------------------------------------
    // Operand paths
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ext_val;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;

    generate
        if (DATA_WIDTH > OPERAND_WIDTH) begin : g_ext_pad
            assign ext_val = {{(DATA_WIDTH - OPERAND_WIDTH){bus_if.operand_in[OPERAND_WIDTH-1]}},
                              bus_if.operand_in};
        end else begin : g_ext_same
            assign ext_val = bus_if.operand_in;
        end
    endgenerate

    assign alu_a = acc_q[bus_if.acc_sel_in];
    assign alu_b = bus_if.sel_B_in ? bus_if.data_memory_in : ext_val;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_z;
    logic                  alu_n;
    logic                  alu_c;
    logic                  alu_v;

    assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
    assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};

    // Result and flags of the selected ALU operation
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus_if.op_alu_in)
            OP_ADD: begin
                alu_res = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
                alu_v   = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ext[DATA_WIDTH-1:0];
                alu_c   = diff_ext[DATA_WIDTH];   // borrow: A < B unsigned
                alu_v   = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
            end
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_XOR: alu_res = alu_a ^ alu_b;
            OP_NOT: alu_res = ~alu_a;
            OP_SHL: begin
                alu_res = {alu_a[MSB-1:0], 1'b0};
                alu_c   = alu_a[MSB];
                alu_v   = alu_a[MSB] ^ alu_a[MSB-1];
            end
            OP_ASR: begin
                alu_res = {alu_a[MSB], alu_a[MSB:1]};
                alu_c   = alu_a[0];
            end
            default: alu_res = '0;
        endcase
`ifdef DATAPATH_SAT_EN
        // On overflow the true result has the sign of A for both ADD and SUB
        if (((bus_if.op_alu_in == OP_ADD) || (bus_if.op_alu_in == OP_SUB)) && alu_v) begin
            alu_res = alu_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`else
        // Two's complement wrap-around: the raw result is kept as is
`endif
        alu_z = (alu_res == '0);
        alu_n = alu_res[MSB];
    end

    // ------------------------------------------------------------------
    // Accumulator write source
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mux_a;

    // Source selection for an IDLE-state accumulator write
    always_comb begin
        case (bus_if.sel_A_in)
            SRC_ALU: mux_a = alu_res;
            SRC_EXT: mux_a = ext_val;
            SRC_MEM: mux_a = bus_if.data_memory_in;
            default: mux_a = alu_a;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier sequencing
    // ------------------------------------------------------------------
    logic idle_start;
    logic idle_cmd;

    assign idle_start = (state_q == ST_IDLE) && bus_if.mul_start_in;
    // Plain register-file commands only act in IDLE and lose to a start
    assign idle_cmd   = (state_q == ST_IDLE) && !bus_if.mul_start_in;

    // Multiplier FSM: latch operands, DATA_WIDTH shift-add steps, write-back
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            dest_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.mul_start_in) begin
                        mcand_q   <= {{DATA_WIDTH{1'b0}}, alu_a};
                        mplier_q  <= alu_b;
                        product_q <= '0;
                        cnt_q     <= '0;
                        dest_q    <= bus_if.acc_sel_in;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mplier_q[0]) begin
                        product_q <= product_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_WB;
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accumulator bank
    // ------------------------------------------------------------------
    logic                     acc_we;
    logic [ACC_SEL_WIDTH-1:0] acc_wsel;
    logic [DATA_WIDTH-1:0]    acc_wdata;

    // Single write port: multiplier write-back or an IDLE-state write
    always_comb begin
        acc_we    = 1'b0;
        acc_wsel  = bus_if.acc_sel_in;
        acc_wdata = mux_a;
        if (state_q == ST_WB) begin
            acc_we    = 1'b1;
            acc_wsel  = dest_q;
            acc_wdata = product_q[DATA_WIDTH-1:0];
        end else if (idle_cmd && bus_if.acc_wr_in && (bus_if.sel_A_in != SRC_HOLD)) begin
            acc_we = 1'b1;
        end
    end

    // Accumulator storage, cleared by reset
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else if (acc_we) begin
            acc_q[acc_wsel] <= acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    // Flags follow the multiply result at write-back, else the ALU on request
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else if (state_q == ST_WB) begin
            flag_z_q <= (product_q[DATA_WIDTH-1:0] == '0);
            flag_n_q <= product_q[DATA_WIDTH-1];
            flag_c_q <= (product_q[PRD_W-1:DATA_WIDTH] != '0);
            flag_v_q <= 1'b0;
        end else if (idle_cmd && bus_if.status_wr_in) begin
            flag_z_q <= alu_z;
            flag_n_q <= alu_n;
            flag_c_q <= alu_c;
            flag_v_q <= alu_v;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_if.data_out                = alu_a;
    assign bus_if.ext_out                 = ext_val;
    assign bus_if.data_memory_address_out = bus_if.operand_in;
    assign bus_if.flag_Z_out              = flag_z_q;
    assign bus_if.flag_N_out              = flag_n_q;
    assign bus_if.flag_C_out              = flag_c_q;
    assign bus_if.flag_V_out              = flag_v_q;
    assign bus_if.busy_out                = (state_q != ST_IDLE);
    assign bus_if.done_out                = (state_q == ST_WB);

    // Start acceptance is visible only through the FSM; keep the term named
    logic unused_idle_start;
    assign unused_idle_start = idle_start;

endmodule
`default_nettype wire

// File: doc/acc_datapath_mc.md
Name: acc_datapath_mc

Overview:
Parametrised successor to the single-accumulator datapath. It provides a bank of NUM_ACC accumulators, an 8-operation ALU with Z/N/C/V status flags, and sign extension of a narrower operand. It also adds a multi-cycle shift-add multiplier with a start/busy/done handshake. It sits between the control unit (selects, writes, op codes, start) and data memory (address out, data in/out).

Parameters:
DATA_WIDTH, 11, width of accumulators, ALU and memory data.
OPERAND_WIDTH, 8, width of the instruction operand field; must be <= DATA_WIDTH.
NUM_ACC, 4, number of accumulators; power of two, >= 2.
ACC_SEL_WIDTH, $clog2(NUM_ACC), derived; do not override.

Ports:
clock_in  input  1  single clock, rising edge
reset_in  input  1  synchronous, active-high reset
operand_in  input  OPERAND_WIDTH  instruction operand
data_memory_in  input  DATA_WIDTH  data read from memory
acc_sel_in  input  ACC_SEL_WIDTH  accumulator that is both ALU A operand and write destination
op_alu_in  input  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL1 A, 111 ASR1 A
sel_A_in  input  2  acc write source: 00 ALU, 01 ext, 10 memory, 11 hold (no write)
sel_B_in  input  1  ALU B source: 0 ext, 1 memory
acc_wr_in  input  1  write selected accumulator
status_wr_in  input  1  update Z/N/C/V from ALU
mul_start_in  input  1  start multiply: acc[acc_sel_in] * B
data_out  output  DATA_WIDTH  acc[acc_sel_in], combinational
ext_out  output  DATA_WIDTH  operand_in sign-extended
data_memory_address_out  output  OPERAND_WIDTH  operand_in passthrough
flag_Z_out, flag_N_out, flag_C_out, flag_V_out  output  1 each  registered status
busy_out  output  1  multiplier running
done_out  output  1  one-cycle pulse in multiplier write-back cycle

Behaviour:
- Reset, synchronous: all accumulators = 0; Z/N/C/V = 0; FSM = IDLE; busy_out = 0; done_out = 0. Reset overrides all other inputs, including an in-flight multiply, which is aborted with no write-back.
- ALU (combinational), A = acc[acc_sel_in], B = mux_B:
  - ADD: C = carry out; V = signed overflow.
  - SUB (A-B): C = borrow (A < B unsigned); V = signed overflow.
  - AND/OR/XOR/NOT: C = 0, V = 0.
  - SHL1: C = A[MSB]; V = A[MSB] ^ A[MSB-1].
  - ASR1: C = A[0], V = 0; sign bit replicated.
  - For every op: Z = (result == 0); N = result[MSB]. B is ignored for NOT/SHL1/ASR1.
- IDLE-state writes, at the clock edge:
  - acc_wr_in=1 and sel_A_in != 11: acc[acc_sel_in] <= mux_A.
  - status_wr_in=1: flags <= ALU flags.
  - Write and flag update are independent and may coincide.
- FSM states IDLE -> RUN -> WB -> IDLE:
  - IDLE: mul_start_in=1 latches multiplicand = acc[acc_sel_in], multiplier = mux_B, dest = acc_sel_in; clears the 2*DATA_WIDTH product and the counter; goes to RUN. mul_start_in has priority: acc_wr_in and status_wr_in are ignored in that cycle.
  - RUN: exactly DATA_WIDTH cycles of unsigned shift-add, one multiplier bit per cycle. Counter counts 0..DATA_WIDTH-1, then goes to WB.
  - WB: one cycle with done_out=1. At the closing edge, acc[dest] <= product[DATA_WIDTH-1:0], Z/N from the low half, C = (high half != 0), V = 0. Then IDLE.
  - busy_out = 1 in RUN and WB.
- Multiply latency: start sampled at edge 0; result visible on data_out (if acc_sel_in = dest) from cycle DATA_WIDTH+2.
- While busy: mul_start_in, acc_wr_in and status_wr_in are ignored. data_out still shows acc[acc_sel_in] (old value).
- Boundary cases:
  - Multiply by 0 gives 0, Z=1.
  - Multiplicand and destination latched at start; later acc_sel_in changes have no effect.
  - Back-to-back start is accepted in the IDLE cycle after WB.

Optional Feature:
Macro DATAPATH_SAT_EN.
- Defined: on signed overflow, ADD/SUB results written to the accumulator saturate to +max (0..011..1) or -min (10..0). V is still set, and Z/N reflect the saturated value.
- Not defined: results wrap (two's complement). The multiplier and other ops are unaffected in both cases.

Test Plan:
- Reset -> all acc = 0x000, Z/N/C/V = 0, busy_out = 0, done_out = 0; apply reset in RUN cycle 4 of a multiply -> no done_out pulse, acc stays 0.
- operand_in=0xF0, sel_A=01, acc_sel=2, acc_wr=1 -> acc2 = 0x7F0, ext_out = 0x7F0, data_memory_address_out = 0xF0.
- acc0=0x3FF, data_memory_in=0x001, ADD, sel_B=1, sel_A=00, acc_wr=1, status_wr=1 -> acc0 = 0x400, N=1, V=1, C=0, Z=0; with DATAPATH_SAT_EN acc0 = 0x3FF, V=1, N=0.
- acc1=5, operand 5, SUB, sel_B=0, status_wr -> Z=1, C=0, V=0; then acc1=3 SUB 5 -> result 0x7FE, C=1, N=1.
- acc3=25, mem=40, mul_start -> busy for 12 cycles, done_out in cycle 12, acc3 = 1000 (0x3E8) from cycle 13, C=0. Then 100*30 -> acc3 = 952 (0x3B8), C=1.
- During busy, pulse acc_wr_in with sel_A=01 on acc3 and assert mul_start_in -> both ignored; only the single write-back of 0x3E8 occurs.
